// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared states, eject_sel encoding and denominations for the change sequencer
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        EJECT    = 3'd2,
        WAIT_ACK = 3'd3,
        FINISH   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_1    = 2'b01;
    localparam logic [1:0] SEL_5    = 2'b10;
    localparam logic [1:0] SEL_10   = 2'b11;

    localparam logic [31:0] DENOM_1  = 32'd1;
    localparam logic [31:0] DENOM_5  = 32'd5;
    localparam logic [31:0] DENOM_10 = 32'd10;

    // Coin value for an eject_sel code; SEL_NONE is worth nothing.
    function automatic logic [31:0] denom_value(input logic [1:0] sel);
        case (sel)
            SEL_1:   denom_value = DENOM_1;
            SEL_5:   denom_value = DENOM_5;
            SEL_10:  denom_value = DENOM_10;
            default: denom_value = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_tube.sv
// rtl/coin_tube.sv - 8-bit saturating coin counter with refill increment and eject decrement
module coin_tube #(
    parameter int unsigned INIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] count
);

    // Simultaneous refill and eject cancel; refill saturates, eject never wraps below zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 8'(INIT);
        end else if (inc && !dec) begin
            if (count != 8'hFF) count <= count + 8'd1;
        end else if (dec && !inc) begin
            if (count != 8'h00) count <= count - 8'd1;
        end
    end

endmodule

// File: rtl/change_sequencer.sv
// rtl/change_sequencer.sv - greedy coin change sequencer over three tubes; optional eject timeout under CHANGE_TIMEOUT_EN
module change_sequencer
    import vend_pkg::*;
#(
    parameter int unsigned TUBE_INIT   = 8,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_amount,
    output logic        req_ready,
    output logic        eject_valid,
    output logic [1:0]  eject_sel,
    input  logic        eject_done,
    input  logic        refill_valid,
    input  logic [1:0]  refill_sel,
    output logic [2:0]  tube_empty,
    output logic        done,
    output logic [31:0] short_amount,
    output logic        fault
);

    state_t      state, next_state;
    logic [31:0] remaining;
    logic [1:0]  sel_q;
    logic [1:0]  pick_sel;
    logic [7:0]  cnt_1, cnt_5, cnt_10;
    logic        timeout_hit;

    assign req_ready   = (state == IDLE);
    assign eject_valid = (state == EJECT);
    assign eject_sel   = eject_valid ? sel_q : SEL_NONE;
    assign done        = (state == FINISH);
    assign tube_empty  = {cnt_10 == 8'd0, cnt_5 == 8'd0, cnt_1 == 8'd0};

    coin_tube #(.INIT(TUBE_INIT)) u_tube_1 (
        .clk(clk), .reset(reset),
        .inc(refill_valid && refill_sel == SEL_1),
        .dec(eject_valid && sel_q == SEL_1),
        .count(cnt_1)
    );
    coin_tube #(.INIT(TUBE_INIT)) u_tube_5 (
        .clk(clk), .reset(reset),
        .inc(refill_valid && refill_sel == SEL_5),
        .dec(eject_valid && sel_q == SEL_5),
        .count(cnt_5)
    );
    coin_tube #(.INIT(TUBE_INIT)) u_tube_10 (
        .clk(clk), .reset(reset),
        .inc(refill_valid && refill_sel == SEL_10),
        .dec(eject_valid && sel_q == SEL_10),
        .count(cnt_10)
    );

    // Greedy pick: largest coin that fits the remainder and is still in stock.
    always_comb begin
        pick_sel = SEL_NONE;
        if (remaining >= DENOM_10 && cnt_10 != 8'd0)     pick_sel = SEL_10;
        else if (remaining >= DENOM_5 && cnt_5 != 8'd0)  pick_sel = SEL_5;
        else if (remaining >= DENOM_1 && cnt_1 != 8'd0)  pick_sel = SEL_1;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (req_valid) next_state = SELECT;
            SELECT:   next_state = (pick_sel == SEL_NONE) ? FINISH : EJECT;
            EJECT:    next_state = WAIT_ACK;
            WAIT_ACK: begin
                if (eject_done)       next_state = SELECT;
                else if (timeout_hit) next_state = FINISH;
            end
            FINISH:   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Remainder bookkeeping; short_amount is loaded on the way into FINISH so it is valid alongside done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining    <= 32'd0;
            sel_q        <= SEL_NONE;
            short_amount <= 32'd0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    remaining    <= req_amount;
                    short_amount <= 32'd0;
                end
                SELECT: begin
                    sel_q <= pick_sel;
                    if (pick_sel == SEL_NONE) short_amount <= remaining;
                end
                EJECT:    remaining <= remaining - denom_value(sel_q);
                WAIT_ACK: if (!eject_done && timeout_hit) short_amount <= remaining;
                default:  ;
            endcase
        end
    end

`ifdef CHANGE_TIMEOUT_EN
    logic [31:0] wait_cnt;
    logic        fault_q;

    assign timeout_hit = (wait_cnt == 32'(TIMEOUT_CYC - 1));
    assign fault       = fault_q;

    // Count WAIT_ACK cycles; give up and flag a fault after TIMEOUT_CYC of them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 32'd0;
            fault_q  <= 1'b0;
        end else begin
            if (state == EJECT)         wait_cnt <= 32'd0;
            else if (state == WAIT_ACK) wait_cnt <= wait_cnt + 32'd1;
            if (state == IDLE && req_valid) fault_q <= 1'b0;
            else if (state == WAIT_ACK && !eject_done && timeout_hit) fault_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_change_sequencer.sv
// tb/tb_change_sequencer.sv - scoreboard bench for change_sequencer
module tb_change_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_amount = 32'd0;
    logic        req_ready;
    logic        eject_valid;
    logic [1:0]  eject_sel;
    logic        eject_done = 1'b0;
    logic        refill_valid = 1'b0;
    logic [1:0]  refill_sel = 2'b00;
    logic [2:0]  tube_empty;
    logic        done;
    logic [31:0] short_amount;
    logic        fault;

    change_sequencer #(.TUBE_INIT(8), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_amount(req_amount),
        .req_ready(req_ready), .eject_valid(eject_valid), .eject_sel(eject_sel),
        .eject_done(eject_done), .refill_valid(refill_valid), .refill_sel(refill_sel),
        .tube_empty(tube_empty), .done(done), .short_amount(short_amount), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [1:0]  sel;
        logic [31:0] short_amt;
        logic        flt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_seen = 0;
    bit   ack_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    task automatic push_ej(input logic [1:0] s);
        exp_t e;
        e.is_done = 1'b0; e.sel = s; e.short_amt = 32'd0; e.flt = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input logic [31:0] sh, input logic f);
        exp_t e;
        e.is_done = 1'b1; e.sel = 2'b00; e.short_amt = sh; e.flt = f;
        exp_q.push_back(e);
    endtask

    // Monitor: pop the next expected event whenever the DUT ejects or finishes.
    always @(negedge clk) begin
        if (!reset) begin
            if (eject_valid) begin
                if (exp_q.size() == 0 || exp_q[0].is_done) flag("unexpected_eject");
                else begin
                    mon_e = exp_q.pop_front();
                    check("eject_sel", 32'(eject_sel), 32'(mon_e.sel));
                end
            end
            if (done) begin
                done_seen++;
                if (exp_q.size() == 0 || !exp_q[0].is_done) flag("unexpected_done");
                else begin
                    mon_e = exp_q.pop_front();
                    check("short_amount", short_amount, mon_e.short_amt);
                    check("fault", 32'(fault), 32'(mon_e.flt));
                end
            end
        end
    end

    // Coin mechanism: acknowledge each eject two cycles later when enabled.
    initial begin
        forever begin
            @(negedge clk);
            if (eject_valid && ack_en) begin
                repeat (2) @(negedge clk);
                eject_done = 1'b1;
                @(negedge clk);
                eject_done = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic issue(input logic [31:0] amt);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) flag("req_ready_timeout");
        req_valid  = 1'b1;
        req_amount = amt;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int lat);
        lat = 1;
        while (!done && lat < bound) begin @(negedge clk); lat++; end
        if (!done) flag("done_timeout");
    endtask

    task automatic wait_eject(input int bound);
        int n = 0;
        while (!eject_valid && n < bound) begin @(negedge clk); n++; end
        if (!eject_valid) flag("eject_timeout");
    endtask

    int lat;
    int ds;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_eject_valid", 32'(eject_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tube_empty", 32'(tube_empty), 32'd0);
        check("rst_short", short_amount, 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        reset = 1'b0;

        // Full tubes, 27 -> 10,10,5,1,1
        push_ej(2'b11); push_ej(2'b11); push_ej(2'b10); push_ej(2'b01); push_ej(2'b01);
        push_done(32'd0, 1'b0);
        issue(32'd27);
        wait_done(400, lat);

        // Drain tube 10 down to one coin: 50 -> five 10s
        for (int i = 0; i < 5; i++) push_ej(2'b11);
        push_done(32'd0, 1'b0);
        issue(32'd50);
        wait_done(400, lat);

        // One 10 left, 25 -> 10,5,5,5
        push_ej(2'b11); push_ej(2'b10); push_ej(2'b10); push_ej(2'b10);
        push_done(32'd0, 1'b0);
        issue(32'd25);
        wait_done(400, lat);
        check("tube10_empty", 32'(tube_empty), 32'b100);

        // Zero amount: no eject, short 0
        push_done(32'd0, 1'b0);
        issue(32'd0);
        wait_done(20, lat);
        check("zero_latency", 32'(lat), 32'd2);

        // Refill tube 5 during an eject of 5 leaves count at 4
        push_ej(2'b10);
        push_done(32'd0, 1'b0);
        issue(32'd5);
        wait_eject(20);
        refill_valid = 1'b1; refill_sel = 2'b10;
        @(negedge clk);
        refill_valid = 1'b0; refill_sel = 2'b00;
        wait_done(40, lat);
        check("tube5_refill_vs_eject", 32'(dut.u_tube_5.count), 32'd4);

        // Saturation: tube 1 holds 6, add 260 coins
        refill_valid = 1'b1; refill_sel = 2'b01;
        repeat (260) @(negedge clk);
        refill_valid = 1'b0; refill_sel = 2'b00;
        check("tube1_saturate", 32'(dut.u_tube_1.count), 32'd255);

        // Reset while waiting for the eject acknowledge
        do_reset();
        ack_en = 1'b0;
        push_ej(2'b11);
        issue(32'd10);
        wait_eject(20);
        @(negedge clk);
        ds = done_seen;
        reset = 1'b1;
        #1;
        check("wrst_req_ready", 32'(req_ready), 32'd1);
        check("wrst_tube10", 32'(dut.u_tube_10.count), 32'd8);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("wrst_no_done", 32'(done_seen), 32'(ds));
        ack_en = 1'b1;

`ifdef CHANGE_TIMEOUT_EN
        // Acknowledge never arrives: 12 -> one 10 paid, fault, short 2
        ack_en = 1'b0;
        push_ej(2'b11);
        push_done(32'd2, 1'b1);
        issue(32'd12);
        wait_done(40, lat);
        ack_en = 1'b1;
        do_reset();
`endif

        // Drain all tubes exactly: 128 = 8x10 + 8x5 + 8x1
        for (int i = 0; i < 8; i++) push_ej(2'b11);
        for (int i = 0; i < 8; i++) push_ej(2'b10);
        for (int i = 0; i < 8; i++) push_ej(2'b01);
        push_done(32'd0, 1'b0);
        issue(32'd128);
        wait_done(2000, lat);
        @(negedge clk);
        check("all_empty", 32'(tube_empty), 32'b111);

        // All empty, 7 -> no eject, done two cycles after accept, short 7
        push_done(32'd7, 1'b0);
        issue(32'd7);
        wait_done(20, lat);
        check("empty_latency", 32'(lat), 32'd2);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/change_sequencer.md
CHANGE_SEQUENCER -- requirements
Module: change_sequencer

Interface
REQ-001 Parameter TUBE_INIT, default 8: coin count loaded into each tube at reset.
REQ-002 Parameter TIMEOUT_CYC, default 255: max WAIT_ACK cycles; used only when CHANGE_TIMEOUT_EN is defined.
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port req_valid  input  1  change request present.
REQ-006 Port req_amount  input  32  change to return, unsigned.
REQ-007 Port req_ready  output  1  high only in IDLE.
REQ-008 Port eject_valid  output  1  one-cycle coin-eject command.
REQ-009 Port eject_sel  output  2  denomination: 01=1, 10=5, 11=10; 00 when eject_valid low.
REQ-010 Port eject_done  input  1  mechanism acknowledges the last eject.
REQ-011 Port refill_valid  input  1  one coin added to tube refill_sel this cycle.
REQ-012 Port refill_sel  input  2  same encoding as eject_sel; 00 ignored.
REQ-013 Port tube_empty  output  3  bit0/1/2 = tube 1/5/10 count is zero.
REQ-014 Port done  output  1  one-cycle pulse at end of a request.
REQ-015 Port short_amount  output  32  change not paid; held from done until the next accept.
REQ-016 Port fault  output  1  eject timeout occurred; held from done until the next accept.

Function
REQ-017 States SHALL be IDLE, SELECT, EJECT, WAIT_ACK, FINISH.
REQ-018 The block SHALL accept on req_valid&&req_ready, latch remaining=req_amount, clear short_amount/fault, and enter SELECT next cycle.
REQ-019 SELECT SHALL pick the largest denomination d with d<=remaining and tube count>0, then go to EJECT; with no such d it SHALL go to FINISH.
REQ-020 EJECT SHALL last exactly one cycle with eject_valid=1 and eject_sel=d; in that same cycle the block SHALL decrement tube d and subtract d from remaining, then go to WAIT_ACK.
REQ-021 WAIT_ACK SHALL hold until eject_done=1, then return to SELECT the next cycle; eject_done outside WAIT_ACK SHALL be ignored.
REQ-022 FINISH SHALL pulse done for one cycle, load short_amount=remaining, and return to IDLE.
REQ-023 req_amount=0 SHALL give IDLE->SELECT->FINISH with short_amount=0.
REQ-024 Refill SHALL increment the selected tube, saturating at 255.
REQ-025 A refill and an eject on the same tube in the same cycle SHALL leave the count unchanged.
REQ-026 tube_empty SHALL be combinational from the tube counts.

Reset
REQ-027 Reset SHALL force IDLE, set all tubes to TUBE_INIT, and set remaining=0, short_amount=0, fault=0, done=0, eject_valid=0.
REQ-028 Reset mid-request SHALL abandon the request with no done pulse.

Configuration
REQ-029 With CHANGE_TIMEOUT_EN defined, WAIT_ACK SHALL count cycles; after TIMEOUT_CYC cycles without eject_done it SHALL set fault=1 and go to FINISH, and the ejected coin SHALL count as paid.
REQ-030 Without CHANGE_TIMEOUT_EN, WAIT_ACK SHALL wait indefinitely, fault SHALL be constant 0, and no timeout counter SHALL exist.

Structure
REQ-031 Package vend_pkg SHALL hold the state enum, the eject_sel encoding, and denomination values 1/5/10.
REQ-032 Sub-module coin_tube SHALL be the 8-bit saturating counter with inc/dec; it SHALL be instantiated three times.

Verification
REQ-033 Full tubes, amount 27 -> ejects 10,10,5,1,1; done with short_amount=0.
REQ-034 Tube-10 count 1, amount 25 -> ejects 10,5,5,5; short_amount=0; tube_empty[2]=1.
REQ-035 All tubes empty, amount 7 -> no eject; done two cycles after accept; short_amount=7.
REQ-036 Refill tube 5 during an eject of 5 -> tube 5 count unchanged; refill with tube at 255 -> count stays 255.
REQ-037 CHANGE_TIMEOUT_EN, TIMEOUT_CYC=4, eject_done never asserted -> fault=1, done asserted, short_amount = amount minus the first coin.
REQ-038 Reset asserted in WAIT_ACK -> IDLE immediately, req_ready=1, tubes=TUBE_INIT, no done pulse.
